carry_skip_sub_serial: RTL
==========================

Name: carry_skip_sub_serial

Overview:
- Multi-cycle, digit-serial subtractor. Computes D = A - B - Bin one BLOCK-bit slice per clock, using borrow-skip logic inside each slice.
- Complements the combinational carry-skip adders. Shares the same 4-bit block partitioning, but runs in the subtract direction.
- Targets area-constrained datapaths where an 8-cycle latency is acceptable.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 32, operand and result width. Must be a positive multiple of BLOCK.
- BLOCK, 4, slice width processed per cycle. Equals the skip-group size.
- NBLK is derived as WIDTH/BLOCK and is not user-settable. Default is 8.

Ports:
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A, B, Bin are valid.
- in_ready  output  1  block can accept operands. High only in IDLE.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result is valid. High only in DONE.
- out_ready  input  1  consumer accepts the result.
- D  output  WIDTH  difference, A - B - Bin mod 2^WIDTH.
- Bout  output  1  unsigned borrow-out. 1 iff A < B + Bin.
- OVF  output  1  two's-complement overflow of the subtraction.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE. out_valid=0, D=0, Bout=0, OVF=0, slice index=0, internal borrow=0.
  - in_ready=1 on the cycle after reset deasserts.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready, latch A, B, Bin into internal registers. Set borrow=Bin and idx=0, then go to RUN.
  - If in_valid=0, stay in IDLE.
- RUN, one slice per cycle:
  - Slice k = bits [k*BLOCK+BLOCK-1 : k*BLOCK] of the latched operands.
  - slice_diff = a_k - b_k - borrow, truncated to BLOCK bits and written into D slice k.
  - Per-bit propagate p_i = (a_i == b_i). Group propagate P = AND of all p_i.
  - Next borrow = borrow if P=1 (skip path); otherwise the ripple borrow of the slice. The result must equal (a_k < b_k + borrow).
  - idx increments. After slice NBLK-1 is processed, latch Bout = final borrow, compute OVF, and go to DONE.
  - in_valid is ignored; input registers do not change.
- OVF = (A[msb] != B[msb]) && (D[msb] != A[msb]), using latched A, B and the final D.
- Latency: handshake at edge t → slices processed at edges t+1 … t+NBLK → out_valid high after edge t+NBLK (8 cycles at default).
- DONE:
  - D, Bout, OVF, and out_valid are held stable while out_ready=0. There is no timeout.
  - On out_valid && out_ready, go to IDLE. out_valid drops and in_ready rises the next cycle.
  - No same-cycle accept of a new operand; minimum issue interval is NBLK+2 cycles.
- D content:
  - In RUN, D reflects partially written slices. Consumers must sample D only while out_valid=1.
  - D, Bout, and OVF keep their last values in IDLE until the next operation overwrites D slice by slice.
- Reset mid-operation (RUN or DONE): the operation is abandoned and the state returns to IDLE as above. No output handshake occurs for it.
- Width rules:
  - All slice arithmetic is BLOCK+1 bits wide internally. The extra bit is the borrow.
  - No sign extension. Bin is a strict 1-bit input.

Test Plan:
- Basic subtract, no backpressure: A=0x00000005, B=0x00000003, Bin=0, out_ready=1.
  → D=0x00000002, Bout=0, OVF=0. out_valid rises exactly 8 cycles after the accept edge and lasts 1 cycle.
- Full skip chain: A=0x00000000, B=0x00000001, Bin=0.
  → D=0xFFFFFFFF, Bout=1, OVF=0. The borrow crosses all 8 slices.
- Equal operands with borrow-in: A=B=0x12345678, Bin=1.
  → D=0xFFFFFFFF, Bout=1, OVF=0. Every slice is all-propagate, so the borrow takes the skip path.
- Signed overflow: A=0x80000000, B=0x00000001, Bin=0.
  → D=0x7FFFFFFF, Bout=0, OVF=1.
  Also A=0x7FFFFFFF, B=0xFFFFFFFF, Bin=0.
  → D=0x80000000, Bout=1, OVF=1.
- Backpressure and input blocking:
  - Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
    → D, Bout, OVF stay constant, in_ready stays 0, and no operand is captured.
  - Then set out_ready=1.
    → IDLE, and the new operands are accepted on the following cycle.
- Reset mid-RUN: assert rst for 1 cycle while processing slice 3.
  → Next cycle: IDLE, in_ready=1, out_valid=0, D=0.
  → A subsequent op A=0x00000100, B=0x00000001 gives D=0x000000FF, Bout=0.
  → Then 1000 random operand/Bin/out_ready patterns, each compared against the reference model A-B-Bin.

Source files
------------

// File: rtl/carry_skip_sub_serial.sv
// -----------------------------------------------------------------------------
// carry_skip_sub_serial
//
// Digit-serial subtractor: D = A - B - Bin (mod 2^WIDTH), one BLOCK-bit slice
// per clock. Each slice uses borrow-skip logic: when every bit pair in the
// slice is equal (group propagate), the incoming borrow bypasses the slice
// unchanged. Otherwise the slice's own ripple borrow is used.
//
// Operands enter through a valid/ready handshake and are held in internal
// registers. The result is presented through a second valid/ready handshake.
// Latency is NBLK cycles from the accept edge to out_valid.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   A, B, Bin are valid
//   in_ready   block can accept operands (high only in IDLE)
//   A          minuend, WIDTH bits
//   B          subtrahend, WIDTH bits
//   Bin        borrow-in, 1 bit
//   out_valid  result is valid (high only in DONE)
//   out_ready  consumer accepts the result
//   D          difference, WIDTH bits
//   Bout       unsigned borrow-out: 1 iff A < B + Bin
//   OVF        two's-complement overflow of the subtraction
// -----------------------------------------------------------------------------
module carry_skip_sub_serial #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             OVF
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

  if (BLOCK <= 0 || WIDTH <= 0 || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("carry_skip_sub_serial: WIDTH must be a positive multiple of BLOCK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched operands and working state.
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic [IDXW-1:0]  idx_q;
  logic             bout_q, ovf_q;

  // Current-slice datapath.
  logic [BLOCK-1:0] a_slice, b_slice;
  logic [BLOCK:0]   diff_ext;     // extra MSB is the slice ripple borrow
  logic [BLOCK-1:0] slice_diff;
  logic             group_p;
  logic             borrow_next;
  logic [WIDTH-1:0] d_next;
  logic             ovf_next;
  logic             accept, deliver, last_slice;

  assign accept     = in_valid && in_ready;
  assign deliver    = out_valid && out_ready;
  assign last_slice = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting every combinational output first keeps all paths
    // assigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)     state_d = S_RUN;
      S_RUN:  if (last_slice) state_d = S_DONE;
      S_DONE: if (deliver)    state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign OVF  = ovf_q;

  // ---------------------------------------------------------------------------
  // Slice selection: pick bits [k*BLOCK +: BLOCK] for k == idx.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_slice = a_q[k*BLOCK +: BLOCK];
        b_slice = b_q[k*BLOCK +: BLOCK];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slice arithmetic with borrow skip.
  // A bit pair propagates the borrow when a_i == b_i; if the whole slice
  // propagates, the outgoing borrow is the incoming one and the ripple path
  // is bypassed. Both paths give (a_k < b_k + borrow).
  // ---------------------------------------------------------------------------
  assign diff_ext    = {1'b0, a_slice} - {1'b0, b_slice} - {{BLOCK{1'b0}}, borrow_q};
  assign slice_diff  = diff_ext[BLOCK-1:0];
  assign group_p     = &(~(a_slice ^ b_slice));
  assign borrow_next = group_p ? borrow_q : diff_ext[BLOCK];

  // D with the current slice merged in; at the last slice this is the final D.
  always_comb begin
    d_next = d_q;
    for (int k = 0; k < NBLK; k++) begin
      if (idx_q == IDXW'(k)) d_next[k*BLOCK +: BLOCK] = slice_diff;
    end
  end

  assign ovf_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_next[WIDTH-1] != a_q[WIDTH-1]);

  // ---------------------------------------------------------------------------
  // Operand registers: loaded only on accept, so a reset value is never
  // observed and they carry no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: pure data registers are deliberately left without reset; they are
    // always written before being read, which saves reset routing.
    if (accept) begin
      a_q <= A;
      b_q <= B;
    end
  end

  // ---------------------------------------------------------------------------
  // Working state and results.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            borrow_q <= Bin;
            idx_q    <= '0;
          end
        end
        S_RUN: begin
          d_q      <= d_next;
          borrow_q <= borrow_next;
          idx_q    <= idx_q + IDXW'(1);
          if (last_slice) begin
            bout_q <= borrow_next;
            ovf_q  <= ovf_next;
          end
        end
        default: ;  // DONE holds results until delivered
      endcase
    end
  end

endmodule
